tdt_dmi_apb_master: RTL and testbench



---
 rtl/tdt_dmi_apb_master_if.sv | 42 ++++
 rtl/tdt_dmi_apb_master.sv | 152 +++++++++++++++
 tb/tb_tdt_dmi_apb_master.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tdt_dmi_apb_master_if.sv
// Bus bundle between the DTM request side and the DM APB side of the DMI APB master.
//   dtm_apbm_*  : single-cycle DMI request from the DTM
//   apbm_dtm_*  : read data, ready and error status back to the DTM
//   apbm_dm_*   : APB3 master signals toward the DM register file
//   dm_apbm_*   : APB3 slave response
// Modport master is the bridge view; modport slave is the surrounding (DTM + DM) view.
interface tdt_dmi_apb_master_if #(
    parameter int unsigned DTM_ABITS = 16
);
    logic                   dtm_apbm_wr_vld;
    logic [DTM_ABITS-1:0]   dtm_apbm_wr_addr;
    logic [1:0]             dtm_apbm_wr_flg;
    logic [31:0]            dtm_apbm_wdata;

    logic [31:0]            apbm_dtm_rdata;
    logic                   apbm_dtm_wr_ready;
    logic                   apbm_dtm_err;

    logic                   apbm_dm_psel;
    logic                   apbm_dm_penable;
    logic                   apbm_dm_pwrite;
    logic [DTM_ABITS+1:0]   apbm_dm_paddr;
    logic [31:0]            apbm_dm_pwdata;

    logic [31:0]            dm_apbm_prdata;
    logic                   dm_apbm_pready;
    logic                   dm_apbm_pslverr;

    modport master (
        input  dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
        input  dm_apbm_prdata, dm_apbm_pready, dm_apbm_pslverr,
        output apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
        output apbm_dm_psel, apbm_dm_penable, apbm_dm_pwrite, apbm_dm_paddr, apbm_dm_pwdata
    );

    modport slave (
        output dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
        output dm_apbm_prdata, dm_apbm_pready, dm_apbm_pslverr,
        input  apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
        input  apbm_dm_psel, apbm_dm_penable, apbm_dm_pwrite, apbm_dm_paddr, apbm_dm_pwdata
    );
endinterface

// File: rtl/tdt_dmi_apb_master.sv
// DMI-to-APB3 master bridge: takes single-cycle read/write requests from the DTM,
// runs each as an APB3 transfer to the debug module, and reports read data,
// idle/ready and error status back to the DTM.
// Ports:
//   tclk          clock, rising edge
//   trst          asynchronous active-high reset
//   dmihardreset  synchronous DMI hard reset; clears rdata/err (at completion if busy)
//   bus           tdt_dmi_apb_master_if.master (DTM request/response + APB3 master)
// Parameters:
//   DTM_ABITS     DMI word address width
//   TIMEOUT       ACCESS cycles allowed before abort (0 disables)
module tdt_dmi_apb_master #(
    parameter int unsigned DTM_ABITS = 16,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                        tclk,
    input  logic                        trst,
    input  logic                        dmihardreset,
    tdt_dmi_apb_master_if.master        bus
);

    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PADDR_W = DTM_ABITS + 2;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 discard;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [PADDR_W-1:0]   paddr;
    logic [31:0]          pwdata;
    logic [31:0]          rdata;
    logic                 err;

    logic                 req_ok_c;
    logic                 timeout_c;
    logic                 drop_c;

    // Only read (1) and write (2) op codes start an APB transfer.
    assign req_ok_c  = bus.dtm_apbm_wr_vld &&
                       ((bus.dtm_apbm_wr_flg == 2'd1) || (bus.dtm_apbm_wr_flg == 2'd2));
    assign timeout_c = TO_EN && (cnt == CNT_LAST);
    // Result of the in-flight transfer is thrown away if a hard reset was seen during it.
    assign drop_c    = discard || dmihardreset;

    // Bridge FSM with registered APB and DTM-side outputs.
    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            state   <= IDLE;
            cnt     <= '0;
            discard <= 1'b0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmihardreset) begin
                        // Hard reset wins over a same-cycle request.
                        rdata <= '0;
                        err   <= 1'b0;
                    end else if (req_ok_c) begin
                        paddr   <= {bus.dtm_apbm_wr_addr, 2'b00};
                        pwdata  <= bus.dtm_apbm_wdata;
                        pwrite  <= bus.dtm_apbm_wr_flg[1];
                        err     <= 1'b0;
                        cnt     <= '0;
                        discard <= 1'b0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (dmihardreset) begin
                        discard <= 1'b1;
                    end
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (cnt != CNT_SAT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (bus.dm_apbm_pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        discard <= 1'b0;
                        state   <= IDLE;
                        if (drop_c) begin
                            rdata <= '0;
                            err   <= 1'b0;
                        end else begin
                            if (!pwrite) begin
                                rdata <= bus.dm_apbm_prdata;
                            end
                            err <= bus.dm_apbm_pslverr;
                        end
                    end else if (timeout_c) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        discard <= 1'b0;
                        state   <= IDLE;
                        if (drop_c) begin
                            rdata <= '0;
                            err   <= 1'b0;
                        end else begin
                            if (!pwrite) begin
                                rdata <= 32'hFFFF_FFFF;
                            end
                            err <= 1'b1;
                        end
                    end else if (dmihardreset) begin
                        discard <= 1'b1;
                    end
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.apbm_dtm_wr_ready = (state == IDLE);
    assign bus.apbm_dtm_rdata    = rdata;
    assign bus.apbm_dtm_err      = err;
    assign bus.apbm_dm_psel      = psel;
    assign bus.apbm_dm_penable   = penable;
    assign bus.apbm_dm_pwrite    = pwrite;
    assign bus.apbm_dm_paddr     = paddr;
    assign bus.apbm_dm_pwdata    = pwdata;

endmodule

// File: tb/tb_tdt_dmi_apb_master.sv
// Directed bench for tdt_dmi_apb_master (TIMEOUT=4).
module tb_tdt_dmi_apb_master;

    logic tclk;
    logic trst;
    logic dmihardreset;
    int   total;
    int   bad;

    tdt_dmi_apb_master_if #(.DTM_ABITS(16)) bus ();

    tdt_dmi_apb_master #(.DTM_ABITS(16), .TIMEOUT(4)) dut (
        .tclk         (tclk),
        .trst         (trst),
        .dmihardreset (dmihardreset),
        .bus          (bus)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    // Present a request for one edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] flg, input logic [15:0] addr, input logic [31:0] wd);
        bus.dtm_apbm_wr_vld  = 1'b1;
        bus.dtm_apbm_wr_flg  = flg;
        bus.dtm_apbm_wr_addr = addr;
        bus.dtm_apbm_wdata   = wd;
        @(posedge tclk); #1;
        bus.dtm_apbm_wr_vld  = 1'b0;
    endtask

    task automatic step();
        @(posedge tclk); #1;
    endtask

    task automatic test_reset();
        trst = 1'b1; dmihardreset = 1'b0;
        bus.dtm_apbm_wr_vld = 1'b0; bus.dtm_apbm_wr_flg = 2'd0;
        bus.dtm_apbm_wr_addr = '0; bus.dtm_apbm_wdata = '0;
        bus.dm_apbm_prdata = '0; bus.dm_apbm_pready = 1'b0; bus.dm_apbm_pslverr = 1'b0;
        repeat (3) @(posedge tclk);
        #1;
        total++; if (bus.apbm_dtm_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.apbm_dtm_wr_ready); end
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable, bus.apbm_dm_pwrite, bus.apbm_dtm_err} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.apbm_dm_psel, bus.apbm_dm_penable, bus.apbm_dm_pwrite, bus.apbm_dtm_err}); end
        total++; if (bus.apbm_dm_paddr !== 18'h0) begin bad++; $display("FAIL reset_paddr got=%h want=0", bus.apbm_dm_paddr); end
        total++; if (bus.apbm_dm_pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata got=%h want=0", bus.apbm_dm_pwdata); end
        total++; if (bus.apbm_dtm_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.apbm_dtm_rdata); end
        @(negedge tclk); trst = 1'b0;
        @(posedge tclk); #1;
    endtask

    task automatic test_read_zero_wait();
        issue(2'd1, 16'h0010, 32'h0);
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable} !== 2'b10) begin bad++; $display("FAIL rd_setup got=%b want=10", {bus.apbm_dm_psel, bus.apbm_dm_penable}); end
        total++; if (bus.apbm_dm_paddr !== 18'h00040) begin bad++; $display("FAIL rd_paddr got=%h want=00040", bus.apbm_dm_paddr); end
        total++; if (bus.apbm_dtm_wr_ready !== 1'b0) begin bad++; $display("FAIL rd_busy got=%b want=0", bus.apbm_dtm_wr_ready); end
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'h1234_5678;
        step();
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable} !== 2'b11) begin bad++; $display("FAIL rd_access got=%b want=11", {bus.apbm_dm_psel, bus.apbm_dm_penable}); end
        step();
        bus.dm_apbm_pready = 1'b0;
        total++; if (bus.apbm_dtm_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got=%h want=12345678", bus.apbm_dtm_rdata); end
        total++; if ({bus.apbm_dtm_wr_ready, bus.apbm_dm_psel, bus.apbm_dtm_err} !== 3'b100) begin bad++; $display("FAIL rd_done got=%b want=100", {bus.apbm_dtm_wr_ready, bus.apbm_dm_psel, bus.apbm_dtm_err}); end
    endtask

    task automatic test_write_wait();
        issue(2'd2, 16'h0004, 32'hDEAD_BEEF);
        total++; if ({bus.apbm_dm_pwrite, bus.apbm_dm_paddr} !== {1'b1, 18'h00010}) begin bad++; $display("FAIL wr_setup got=%b/%h want=1/00010", bus.apbm_dm_pwrite, bus.apbm_dm_paddr); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if ({bus.apbm_dm_pwdata, bus.apbm_dtm_wr_ready, bus.apbm_dm_penable} !== {32'hDEAD_BEEF, 2'b01}) begin bad++; $display("FAIL wr_hold%0d got=%h/%b/%b want=deadbeef/0/1", i, bus.apbm_dm_pwdata, bus.apbm_dtm_wr_ready, bus.apbm_dm_penable); end
        end
        bus.dm_apbm_pready = 1'b1;
        step();
        bus.dm_apbm_pready = 1'b0;
        total++; if (bus.apbm_dtm_wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", bus.apbm_dtm_wr_ready); end
        total++; if (bus.apbm_dtm_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_rdata_kept got=%h want=12345678", bus.apbm_dtm_rdata); end
        total++; if (bus.apbm_dm_pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_pwdata_after got=%h want=deadbeef", bus.apbm_dm_pwdata); end
    endtask

    task automatic test_slave_error();
        issue(2'd1, 16'h0020, 32'h0);
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'hA5A5_0001; bus.dm_apbm_pslverr = 1'b1;
        step(); step();
        bus.dm_apbm_pready = 1'b0; bus.dm_apbm_pslverr = 1'b0;
        total++; if (bus.apbm_dtm_err !== 1'b1) begin bad++; $display("FAIL slverr_err got=%b want=1", bus.apbm_dtm_err); end
        total++; if (bus.apbm_dtm_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL slverr_rdata got=%h want=a5a50001", bus.apbm_dtm_rdata); end
        issue(2'd1, 16'h0021, 32'h0);
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'h0BAD_F00D;
        step(); step();
        bus.dm_apbm_pready = 1'b0;
        total++; if ({bus.apbm_dtm_err, bus.apbm_dtm_rdata} !== {1'b0, 32'h0BAD_F00D}) begin bad++; $display("FAIL slverr_clear got=%b/%h want=0/0badf00d", bus.apbm_dtm_err, bus.apbm_dtm_rdata); end
    endtask

    task automatic test_timeout();
        issue(2'd1, 16'h0030, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready} !== 2'b10) begin bad++; $display("FAIL to_wait%0d got=%b want=10", i, {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready}); end
        end
        step();
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable, bus.apbm_dtm_wr_ready, bus.apbm_dtm_err} !== 4'b0011) begin bad++; $display("FAIL to_abort got=%b want=0011", {bus.apbm_dm_psel, bus.apbm_dm_penable, bus.apbm_dtm_wr_ready, bus.apbm_dtm_err}); end
        total++; if (bus.apbm_dtm_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL to_rdata got=%h want=ffffffff", bus.apbm_dtm_rdata); end
    endtask

    task automatic test_nop_busy();
        issue(2'd0, 16'h0011, 32'h0);
        total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready} !== 2'b01) begin bad++; $display("FAIL nop_flg0 got=%b want=01", {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready}); end
        issue(2'd3, 16'h0012, 32'h0);
        total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready} !== 2'b01) begin bad++; $display("FAIL nop_flg3 got=%b want=01", {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready}); end
        total++; if ({bus.apbm_dtm_err, bus.apbm_dtm_rdata} !== {1'b1, 32'hFFFF_FFFF}) begin bad++; $display("FAIL nop_status got=%b/%h want=1/ffffffff", bus.apbm_dtm_err, bus.apbm_dtm_rdata); end
        issue(2'd2, 16'h0008, 32'h1111_2222);
        step();
        issue(2'd2, 16'h03FF, 32'h9999_9999);
        total++; if ({bus.apbm_dm_paddr, bus.apbm_dm_pwdata} !== {18'h00020, 32'h1111_2222}) begin bad++; $display("FAIL busy_hold got=%h/%h want=00020/11112222", bus.apbm_dm_paddr, bus.apbm_dm_pwdata); end
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable} !== 2'b11) begin bad++; $display("FAIL busy_access got=%b want=11", {bus.apbm_dm_psel, bus.apbm_dm_penable}); end
        bus.dm_apbm_pready = 1'b1;
        step();
        bus.dm_apbm_pready = 1'b0;
        total++; if ({bus.apbm_dtm_wr_ready, bus.apbm_dtm_err, bus.apbm_dtm_rdata} !== {2'b10, 32'hFFFF_FFFF}) begin bad++; $display("FAIL busy_done got=%b%b/%h want=10/ffffffff", bus.apbm_dtm_wr_ready, bus.apbm_dtm_err, bus.apbm_dtm_rdata); end
        step();
        total++; if (bus.apbm_dm_psel !== 1'b0) begin bad++; $display("FAIL busy_no_restart got=%b want=0", bus.apbm_dm_psel); end
    endtask

    task automatic test_back_to_back();
        issue(2'd1, 16'h0001, 32'h0);
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'h0000_0001;
        step(); step();
        bus.dm_apbm_pready = 1'b0;
        total++; if ({bus.apbm_dtm_wr_ready, bus.apbm_dtm_rdata} !== {1'b1, 32'h1}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/00000001", bus.apbm_dtm_wr_ready, bus.apbm_dtm_rdata); end
        issue(2'd1, 16'h0002, 32'h0);
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_paddr} !== {1'b1, 18'h00008}) begin bad++; $display("FAIL b2b_accept got=%b/%h want=1/00008", bus.apbm_dm_psel, bus.apbm_dm_paddr); end
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'h0000_0002;
        step(); step();
        bus.dm_apbm_pready = 1'b0;
        total++; if ({bus.apbm_dtm_wr_ready, bus.apbm_dtm_rdata} !== {1'b1, 32'h2}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/00000002", bus.apbm_dtm_wr_ready, bus.apbm_dtm_rdata); end
    endtask

    task automatic test_hardreset();
        issue(2'd1, 16'h0040, 32'h0);
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'hCAFE_0000; bus.dm_apbm_pslverr = 1'b1;
        step(); step();
        bus.dm_apbm_pready = 1'b0; bus.dm_apbm_pslverr = 1'b0;
        dmihardreset = 1'b1;
        bus.dtm_apbm_wr_vld = 1'b1; bus.dtm_apbm_wr_flg = 2'd1; bus.dtm_apbm_wr_addr = 16'h0041;
        step();
        dmihardreset = 1'b0; bus.dtm_apbm_wr_vld = 1'b0;
        total++; if ({bus.apbm_dtm_err, bus.apbm_dtm_rdata} !== {1'b0, 32'h0}) begin bad++; $display("FAIL hrst_idle got=%b/%h want=0/00000000", bus.apbm_dtm_err, bus.apbm_dtm_rdata); end
        total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready} !== 2'b01) begin bad++; $display("FAIL hrst_drop_req got=%b want=01", {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready}); end
        issue(2'd1, 16'h0042, 32'h0);
        step();
        dmihardreset = 1'b1;
        step();
        dmihardreset = 1'b0;
        total++; if ({bus.apbm_dm_psel, bus.apbm_dm_penable} !== 2'b11) begin bad++; $display("FAIL hrst_continue got=%b want=11", {bus.apbm_dm_psel, bus.apbm_dm_penable}); end
        bus.dm_apbm_pready = 1'b1; bus.dm_apbm_prdata = 32'h0000_0055; bus.dm_apbm_pslverr = 1'b1;
        step();
        bus.dm_apbm_pready = 1'b0; bus.dm_apbm_pslverr = 1'b0;
        total++; if ({bus.apbm_dtm_wr_ready, bus.apbm_dtm_err, bus.apbm_dtm_rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL hrst_access got=%b%b/%h want=10/00000000", bus.apbm_dtm_wr_ready, bus.apbm_dtm_err, bus.apbm_dtm_rdata); end
    endtask

    task automatic test_trst_setup();
        issue(2'd2, 16'h0050, 32'h7777_8888);
        total++; if (bus.apbm_dm_psel !== 1'b1) begin bad++; $display("FAIL trst_pre got=%b want=1", bus.apbm_dm_psel); end
        #1 trst = 1'b1;
        #1;
        total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready, bus.apbm_dm_pwrite} !== 3'b010) begin bad++; $display("FAIL trst_async got=%b want=010", {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready, bus.apbm_dm_pwrite}); end
        total++; if ({bus.apbm_dm_paddr, bus.apbm_dm_pwdata} !== 50'h0) begin bad++; $display("FAIL trst_bus got=%h/%h want=0/0", bus.apbm_dm_paddr, bus.apbm_dm_pwdata); end
        @(negedge tclk); trst = 1'b0;
        step();
        total++; if ({bus.apbm_dm_psel, bus.apbm_dtm_wr_ready} !== 2'b01) begin bad++; $display("FAIL trst_after got=%b want=01", {bus.apbm_dm_psel, bus.apbm_dtm_wr_ready}); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slave_error();
        test_timeout();
        test_nop_busy();
        test_back_to_back();
        test_hardreset();
        test_trst_setup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
